// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// cache_ctrl : tag/state sequencer for a write-back, write-allocate, true-LRU
//              set-associative cache with hit/miss/writeback statistics.
// Rev 1.0
// ============================================================================
module cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt,
  output logic [CNT_W-1:0]        wb_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << INDEX_W;

  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
  localparam logic [WAY_W-1:0] AGE_ONE = WAY_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               we_q, we_d;
  logic [TAG_W-1:0]   rtag_q, rtag_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]   age_q   [SETS][WAYS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               unused_offset;

  assign req_tag       = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign req_idx       = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  logic [WAYS-1:0]  match;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign match[g] = valid_q[idx_q][g] && (tag_q[idx_q][g] == rtag_q);
    end
  endgenerate

  // Descending scan so the lowest-numbered candidate wins.
  always_comb begin
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!valid_q[idx_q][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[idx_q][w] == AGE_MAX) lru_way = WAY_W'(w);
    end
  end

  assign hit_any = |match;
  assign victim  = inv_any ? inv_way : lru_way;

  logic             acc_en;
  logic [WAY_W-1:0] acc_way;
  logic [WAY_W-1:0] acc_age;

  assign acc_en  = ((state_q == S_LOOKUP) && hit_any) || ((state_q == S_FILL) && mem_ack);
  assign acc_way = (state_q == S_LOOKUP) ? hit_way : way_q;
  assign acc_age = age_q[idx_q][acc_way];

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    rtag_d     = rtag_q;
    idx_d      = idx_q;
    way_d      = way_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          rtag_d  = req_tag;
          idx_d   = req_idx;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          hit_d     = 1'b1;
          way_d     = hit_way;
          hit_cnt_d = hit_cnt_q + CNT_ONE;
          state_d   = S_RESP;
        end else begin
          hit_d      = 1'b0;
          way_d      = victim;
          miss_cnt_d = miss_cnt_q + CNT_ONE;
          state_d    = (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_ack) begin
          wb_cnt_d = wb_cnt_q + CNT_ONE;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      rtag_q     <= '0;
      idx_q      <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      rtag_q     <= rtag_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // Tag store; ages start as the identity permutation so way WAYS-1 is LRU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if ((state_q == S_LOOKUP) && hit_any && we_q) begin
        dirty_q[idx_q][hit_way] <= 1'b1;
      end
      if ((state_q == S_FILL) && mem_ack) begin
        valid_q[idx_q][way_q] <= 1'b1;
        dirty_q[idx_q][way_q] <= we_q;
        tag_q[idx_q][way_q]   <= rtag_q;
      end
      if (acc_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way) begin
            age_q[idx_q][w] <= '0;
          end else if (age_q[idx_q][w] < acc_age) begin
            age_q[idx_q][w] <= age_q[idx_q][w] + AGE_ONE;
          end
        end
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_hit   = resp_valid & hit_q;
  assign resp_way   = resp_valid ? way_q : '0;
  assign mem_req    = (state_q == S_WB) || (state_q == S_FILL);
  assign mem_we     = (state_q == S_WB);

  always_comb begin
    mem_addr = '0;
    if (state_q == S_WB) begin
      mem_addr = {tag_q[idx_q][way_q], idx_q, {OFFSET_W{1'b0}}};
    end else if (state_q == S_FILL) begin
      mem_addr = {rtag_q, idx_q, {OFFSET_W{1'b0}}};
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cache_ctrl : directed self-checking bench for cache_ctrl (default params).
// Rev 1.0
// ============================================================================
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wb_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Results of the most recent access().
  logic        a_hit;
  logic [1:0]  a_way;
  int          a_lat;
  int          a_acc;
  bit          a_wb;
  bit          a_fill;
  bit          a_mem_seen;
  bit          a_stable;
  bit          a_busy_ready;
  logic [31:0] a_wb_addr;
  logic [31:0] a_fill_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    rst_n     = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Issue one request, ack each memory phase after dly waiting cycles, and
  // return one cycle after the response (controller back in IDLE).
  task automatic access(input logic we, input logic [31:0] addr, input int dly, input bit hold);
    int          wait_c;
    bit          in_ph;
    bit          done;
    logic [31:0] ph_addr;
    logic        ph_we;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    a_hit = 1'b0; a_way = '0; a_lat = 0; a_acc = 0;
    a_wb = 1'b0; a_fill = 1'b0; a_mem_seen = 1'b0; a_stable = 1'b1; a_busy_ready = 1'b0;
    a_wb_addr = '0; a_fill_addr = '0;
    wait_c = 0; in_ph = 1'b0; done = 1'b0; ph_addr = '0; ph_we = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (req_valid && req_ready) a_acc++;
      if (c > 0 && req_ready) a_busy_ready = 1'b1;
      step();
      a_lat++;
      if (!hold) req_valid = 1'b0;
      mem_ack = 1'b0;
      if (resp_valid) begin
        a_hit = resp_hit;
        a_way = resp_way;
        done  = 1'b1;
      end else if (mem_req) begin
        a_mem_seen = 1'b1;
        if (!in_ph) begin
          in_ph   = 1'b1;
          ph_addr = mem_addr;
          ph_we   = mem_we;
          wait_c  = 0;
        end else if (mem_addr !== ph_addr || mem_we !== ph_we) begin
          a_stable = 1'b0;
        end
        if (wait_c == dly) begin
          mem_ack = 1'b1;
          in_ph   = 1'b0;
          if (mem_we) begin
            a_wb = 1'b1; a_wb_addr = mem_addr;
          end else begin
            a_fill = 1'b1; a_fill_addr = mem_addr;
          end
        end else begin
          wait_c++;
        end
      end
    end
    mem_ack = 1'b0;
    if (!done) check("resp_timeout", 64'd0, 64'd1);
    step();
    check("resp_single_pulse", resp_valid, 1'b0);
    if (hold) begin
      check("ready_after_resp", req_ready, 1'b1);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_resp_way", resp_way, 2'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    check("rst_wb_cnt", wb_cnt, 32'd0);

    // Cold read miss, fill acked after 2 waiting cycles
    access(1'b0, 32'h1040, 2, 1'b0);
    check("cold_hit", a_hit, 1'b0);
    check("cold_way", a_way, 2'd0);
    check("cold_lat", a_lat, 5);
    check("cold_fill", a_fill, 1'b1);
    check("cold_fill_addr", a_fill_addr, 32'h1040);
    check("cold_no_wb", a_wb, 1'b0);
    check("cold_stable", a_stable, 1'b1);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);

    // Repeat read in same line hits
    access(1'b0, 32'h1047, 0, 1'b0);
    check("rehit_hit", a_hit, 1'b1);
    check("rehit_way", a_way, 2'd0);
    check("rehit_lat", a_lat, 2);
    check("rehit_no_mem", a_mem_seen, 1'b0);
    check("rehit_hit_cnt", hit_cnt, 32'd1);
    check("rehit_miss_cnt", miss_cnt, 32'd1);

    // mem_ack while idle is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_mem_req", mem_req, 1'b0);
    check("idle_ack_ready", req_ready, 1'b1);
    check("idle_ack_resp", resp_valid, 1'b0);
    step();
    check("idle_ack_mem_req2", mem_req, 1'b0);
    check("idle_ack_hit_cnt", hit_cnt, 32'd1);
    check("idle_ack_miss_cnt", miss_cnt, 32'd1);
    check("idle_ack_wb_cnt", wb_cnt, 32'd0);

    // req_valid held through a miss: exactly one accept
    access(1'b0, 32'h2000, 1, 1'b1);
    check("hold_accepts", a_acc, 1);
    check("hold_busy_ready", a_busy_ready, 1'b0);
    check("hold_hit", a_hit, 1'b0);
    check("hold_fill_addr", a_fill_addr, 32'h2000);
    step();
    check("hold_no_reaccept", req_ready, 1'b1);
    check("hold_miss_cnt", miss_cnt, 32'd2);

    // Asynchronous reset in the middle of FILL
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000;
    step();
    req_valid = 1'b0;
    step();
    check("midfill_mem_req", mem_req, 1'b1);
    check("midfill_mem_addr", mem_addr, 32'h3000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 1'b0);
    check("async_rst_mem_addr", mem_addr, 32'h0);
    check("async_rst_ready", req_ready, 1'b1);
    check("async_rst_hit_cnt", hit_cnt, 32'd0);
    check("async_rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    access(1'b0, 32'h1040, 0, 1'b0);
    check("post_rst_hit", a_hit, 1'b0);
    check("post_rst_way", a_way, 2'd0);
    check("post_rst_lat", a_lat, 3);
    check("post_rst_miss_cnt", miss_cnt, 32'd1);

    // Fill set 1 with dirty lines, then evict the LRU dirty way
    do_reset();
    access(1'b1, 32'h0440, 0, 1'b0);
    check("w440_way", a_way, 2'd0);
    access(1'b1, 32'h0840, 0, 1'b0);
    check("w840_way", a_way, 2'd1);
    access(1'b1, 32'h0C40, 0, 1'b0);
    check("wC40_way", a_way, 2'd2);
    access(1'b1, 32'h1040, 0, 1'b0);
    check("w1040_way", a_way, 2'd3);
    check("w1040_lat", a_lat, 3);
    access(1'b0, 32'h1440, 1, 1'b0);
    check("evict_hit", a_hit, 1'b0);
    check("evict_wb", a_wb, 1'b1);
    check("evict_wb_addr", a_wb_addr, 32'h0440);
    check("evict_fill_addr", a_fill_addr, 32'h1440);
    check("evict_way", a_way, 2'd0);
    check("evict_lat", a_lat, 6);
    check("evict_stable", a_stable, 1'b1);
    check("evict_wb_cnt", wb_cnt, 32'd1);
    check("evict_miss_cnt", miss_cnt, 32'd5);

    // LRU order on set 2: tags 1..4, re-read tag 1, miss tag 5 -> way 1
    access(1'b0, 32'h0480, 0, 1'b0);
    access(1'b0, 32'h0880, 0, 1'b0);
    access(1'b0, 32'h0C80, 0, 1'b0);
    access(1'b0, 32'h1080, 0, 1'b0);
    check("lru_fill4_way", a_way, 2'd3);
    access(1'b0, 32'h0480, 0, 1'b0);
    check("lru_reread_hit", a_hit, 1'b1);
    check("lru_reread_way", a_way, 2'd0);
    access(1'b0, 32'h1480, 0, 1'b0);
    check("lru_victim_way", a_way, 2'd1);
    check("lru_victim_no_wb", a_wb, 1'b0);
    check("lru_victim_fill", a_fill_addr, 32'h1480);

    // Write hit marks a clean line dirty; evicting it later writes back
    access(1'b0, 32'h00C0, 0, 1'b0);
    check("wh_fill_way", a_way, 2'd0);
    access(1'b1, 32'h00C0, 0, 1'b0);
    check("wh_hit", a_hit, 1'b1);
    access(1'b0, 32'h04C0, 0, 1'b0);
    access(1'b0, 32'h08C0, 0, 1'b0);
    access(1'b0, 32'h0CC0, 0, 1'b0);
    check("wh_fill3_way", a_way, 2'd3);
    access(1'b0, 32'h10C0, 0, 1'b0);
    check("wh_evict_wb", a_wb, 1'b1);
    check("wh_evict_wb_addr", a_wb_addr, 32'h00C0);
    check("wh_evict_way", a_way, 2'd0);
    check("final_hit_cnt", hit_cnt, 32'd2);
    check("final_miss_cnt", miss_cnt, 32'd15);
    check("final_wb_cnt", wb_cnt, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the cache simulator's tag store.
- Accepts CPU read/write requests through a valid/ready handshake and splits each address into tag, index and offset using the mypkg widths.
- Performs a set-associative lookup and maintains true-LRU ordering. Writes are write-back and write-allocate.
- On a miss it sequences the memory-side writeback and fill, and it keeps hit, miss and writeback statistics.
- Tags and state only; no data array.

Parameters:
- ADDR_W, 32, address width; equals ADDRESS_BITS.
- OFFSET_W, 6, byte-select bits; equals OFFSET_BITS.
- INDEX_W, 4, set-index bits; equals INDEX_BITS.
- WAYS, 4, associativity; power of 2, at least 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  request hit; valid only with resp_valid.
- resp_way  out  log2(WAYS)  way hit or filled.
- mem_req  out  1  memory transaction pending.
- mem_we  out  1  1 = writeback, 0 = fill.
- mem_addr  out  ADDR_W  line address; offset bits are 0.
- mem_ack  in  1  memory completes the pending transaction.
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W  statistics.

Behaviour:
- Field split: TAG_W = ADDR_W-INDEX_W-OFFSET_W. tag = addr[ADDR_W-1:INDEX_W+OFFSET_W]; index = addr[INDEX_W+OFFSET_W-1:OFFSET_W].
- Per set and way, store: valid, dirty, tag, and age (log2(WAYS) bits).
- Reset (asynchronous, any state):
  - All valid and dirty bits = 0; age of way w = w.
  - All counters = 0; state = IDLE.
  - req_ready = 1; resp_valid, resp_hit, resp_way, mem_req, mem_we and mem_addr = 0.
- IDLE: req_ready = 1. A handshake (req_valid & req_ready) registers we, tag and index, then moves to LOOKUP.
- LOOKUP (1 cycle), req_ready = 0:
  - Hit means a valid way with a matching tag. At most one way can match.
  - On hit: hit_cnt++; if we, set dirty; update LRU; go to RESP.
  - On miss: miss_cnt++ and pick a victim:
    - the lowest-index invalid way, else
    - the way with age WAYS-1.
  - If the victim is valid and dirty: go to WB, else go to FILL.
- WB:
  - mem_req = 1, mem_we = 1.
  - mem_addr = {victim tag, index, 0s}.
  - mem_addr and mem_we are held stable until mem_ack.
  - On mem_ack: wb_cnt++, go to FILL.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {req tag, index, 0s}.
  - On mem_ack: victim gets valid = 1, tag = req tag, dirty = we; update LRU; go to RESP.
- WB-to-FILL transition: mem_req stays 1; mem_we and mem_addr change in the same edge as the ack.
- RESP (1 cycle):
  - resp_valid = 1; resp_hit = 1 for hit, 0 for miss; resp_way set.
  - Next state IDLE. resp_valid is 0 in all other states.
- Latency:
  - Hit: resp_valid rises 2 cycles after the accept edge.
  - Clean miss with mem_ack at the first FILL cycle: 3 cycles.
  - Each ack wait adds its delay.
- LRU update on access to way a with old age A:
  - Every way in the set with age < A increments.
  - Way a becomes 0.
  - Ages remain a permutation of 0..WAYS-1.
- mem_ack outside WB/FILL is ignored. req_valid while req_ready = 0 is ignored; the requester holds it.
- Counters wrap at 2^CNT_W.
- Back-to-back requests: the next accept is possible the cycle after RESP.

Test Plan:
- Examples use defaults (index = addr[9:6], tag = addr[31:10]).
- Cold read to 0x1040 (index 1, tag 4), mem_ack after 2 cycles:
  - mem_req=1, mem_we=0, mem_addr=0x1040.
  - Then resp_valid with resp_hit=0, resp_way=0; miss_cnt=1.
- Repeat read to 0x1047:
  - resp_hit=1, resp_way=0 exactly 2 cycles after accept.
  - No mem_req; hit_cnt=1.
- Write 0x440, 0x840, 0xC40 and 0x1040 (index 1), then read 0x1440:
  - Writeback to mem_addr=0x440 with mem_we=1, then fill of 0x1440 into way 0.
  - wb_cnt=1, miss_cnt=5.
- LRU order: on a fresh set, access tags 1, 2, 3, 4 (ways 0-3), re-read tag 1, then miss on tag 5:
  - The victim is way 1 (tag 2).
- Hold req_valid=1 with 0x2000 during a miss:
  - req_ready=0 until back in IDLE; exactly one accept.
  - mem_ack pulsed while in IDLE causes no state change.
- Drive rst_n=0 mid-FILL:
  - mem_req=0 immediately, without waiting for clk.
  - Counters become 0; a re-read of a previously filled address misses.
